mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester round-robin arbiter sharing one memory port between instruction fetch (requester 0) and load/store (requester 1). It drives the select of the existing 32-bit `Mux` that steers address and write data onto the shared port. It sequences each access as a grant/busy/complete handshake against a variable-latency memory. It sits between the core's fetch/LSU front ends and the unified memory model.

## Interface
- `ADDR_W`, 32, address width; must equal 32 to match `Mux`.
- `DATA_W`, 32, data width; must equal 32.
- `TIMEOUT`, 16, BUSY cycles without `m_ready` before abort; only used with the timeout feature; must be ≥ 2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `r0_req`, `r1_req`  in  1 each  access request; held high until that requester's done.
- `r0_addr`, `r1_addr`  in  ADDR_W each  address; stable while req high.
- `r0_wdata`, `r1_wdata`  in  DATA_W each  write data; stable while req high.
- `r0_we`, `r1_we`  in  1 each  write enable; stable while req high.
- `r0_gnt`, `r1_gnt`  out  1 each  high every BUSY cycle for the granted requester.
- `r0_done`, `r1_done`  out  1 each  one-cycle completion pulse, combinational.
- `rdata`  out  DATA_W  equals `m_rdata`; valid only in a done cycle.
- `err`  out  1  access aborted by timeout; qualifies done.
- `sel`  out  1  registered mux select (0 = r0, 1 = r1).
- `m_req`  out  1  memory request; high throughout BUSY.
- `m_addr`, `m_wdata`, `m_we`  out  ADDR_W/DATA_W/1  muxed from the selected requester.
- `m_ready`  in  1  memory completes the access in this cycle.
- `m_rdata`  in  DATA_W  read data, valid with `m_ready`.

## Operation
- FSM states: IDLE, BUSY.
- IDLE with any req: winner chosen, then at the clock edge: `sel`←winner, `last`←winner, state←BUSY.
- Single req wins outright. Both high: the requester ≠ `last` wins (strict alternation).
- BUSY: `m_req`=1; `rX_gnt`=1 for X=`sel`; `m_addr`/`m_wdata`/`m_we` follow requester `sel`.
- BUSY with `m_ready`=1: `rX_done`=1 in the same cycle, `rdata`=`m_rdata`; next state IDLE.
- `m_we` is gated by `m_req`, so it is 0 in IDLE.
- `sel` holds its value in IDLE and changes only on an IDLE→BUSY edge.
- Reset values: state IDLE, `sel`=0, `last`=1 (r0 wins the first tie); `m_req`, all gnt/done, and `err` are 0.
- Reset mid-BUSY: transaction abandoned, no done pulse; `m_req` is 0 from the first cycle after the reset edge.
- req dropped while BUSY (protocol violation): ignored; the transaction completes normally.

## Timing
- req sampled high in cycle N (IDLE) → `m_req`/gnt high from N+1.
- Earliest done is N+1 (if `m_ready` is already high).
- Requester deasserts req at the edge ending its done cycle. The next arbitration happens in the following IDLE cycle.
- Throughput: at most one access per 2 cycles. With both requesters saturated, grants alternate r0, r1, r0, …
- No combinational path from req to any memory-port output: `m_*` depend only on registered state, `sel`, and the stable requester data.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without `m_ready`.
  - In the `TIMEOUT`-th consecutive such cycle: `rX_done`=1 and `err`=1 for that cycle, `rdata`=0, next state IDLE.
  - `m_ready` arriving in that same cycle takes priority: normal completion, `err`=0.
- Undefined: no counter; `err` tied to 0; BUSY waits indefinitely for `m_ready`.

## Structure
- Shared package `mem_arb_pkg`:
  - state typedef {IDLE, BUSY};
  - constants `SEL_R0`=0, `SEL_R1`=1;
  - default `TIMEOUT` value.
- Sub-module: two instances of the existing `Mux` (a=r0, b=r1, s=`sel`), one for `m_addr` and one for `m_wdata`.
- `m_we` is a 1-bit select inline.

## Test plan
- Single r0 read, addr 0x00000040, `m_ready` 3 cycles after `m_req`, `m_rdata`=0xDEADBEEF → `r0_done` pulses once with `rdata`=0xDEADBEEF; `sel`=0; `m_we`=0.
- r0 and r1 both requesting continuously, `m_ready` always 1 → grant order r0, r1, r0, r1; one done every 2 cycles; `m_addr` alternates between 0xAAAAAAAA and 0xBBBBBBBB.
- r1 write, addr 0x12345678, wdata 0xCAFEF00D → `m_we`=1, `m_wdata`=0xCAFEF00D during BUSY; `r1_done` pulses; `r0_gnt` stays 0.
- `rst` asserted 2 cycles into BUSY → next cycle `m_req`=0, no done pulse, `sel`=0; a fresh tie then grants r0.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=4, `m_ready` held 0 → done and `err`=1 in the 4th BUSY cycle, then IDLE; repeated with `m_ready`=1 in the 4th cycle → `err`=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared types and constants for the two-requester memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic SEL_R0 = 1'b0;
  localparam logic SEL_R1 = 1'b1;

  localparam int DEFAULT_TIMEOUT = 16;

  // A lone requester wins outright; on a tie the one that did not win last time goes.
  function automatic logic pick_winner(input logic r0_req, input logic r1_req, input logic last);
    if (r0_req && r1_req) begin
      return (last == SEL_R0) ? SEL_R1 : SEL_R0;
    end
    return r1_req ? SEL_R1 : SEL_R0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles both requester ports and the shared memory port of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req/addr/wdata/we until their done pulse.
// Modports: master = arbiter view (requests and memory response in, grants and
// memory request out); slave = the surrounding fetch/LSU front ends and memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              r0_req;
  logic              r1_req;
  logic [ADDR_W-1:0] r0_addr;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [DATA_W-1:0] r1_wdata;
  logic              r0_we;
  logic              r1_we;
  logic              r0_gnt;
  logic              r1_gnt;
  logic              r0_done;
  logic              r1_done;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              sel;
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_we;
  logic              m_ready;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    input  r0_req, r1_req, r0_addr, r1_addr, r0_wdata, r1_wdata, r0_we, r1_we,
    input  m_ready, m_rdata,
    output r0_gnt, r1_gnt, r0_done, r1_done, rdata, err, sel,
    output m_req, m_addr, m_wdata, m_we
  );

  modport slave (
    output r0_req, r1_req, r0_addr, r1_addr, r0_wdata, r1_wdata, r0_we, r1_we,
    output m_ready, m_rdata,
    input  r0_gnt, r1_gnt, r0_done, r1_done, rdata, err, sel,
    input  m_req, m_addr, m_wdata, m_we
  );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// Purpose: 32-bit 2:1 mux (a when s=0, b when s=1) steering requester data onto the port.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b data inputs; s select; y output.
module Mux (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        s,
  output logic [31:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one memory port between fetch (r0) and load/store (r1).
// Latency: grant and m_req one cycle after req seen in IDLE; done is combinational with m_ready.
// Backpressure: BUSY holds until m_ready (or timeout abort); one access per two cycles at most.
// Ports: clk, rst (synchronous, active high); bus = mem_port_arbiter_if.master carrying
// requester req/addr/wdata/we in, gnt/done/rdata/err/sel out, and the memory port.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an access after TIMEOUT BUSY
// cycles without m_ready (done with err=1, rdata=0).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  arb_state_t state;
  logic       sel;
  logic       last;
  logic       m_req_q;
  logic       r0_gnt_q;
  logic       r1_gnt_q;
  logic       winner;
  logic       tmo;
  logic       complete;

  assign winner = pick_winner(bus.r0_req, bus.r1_req, last);

`ifdef MEM_ARB_TIMEOUT_EN
  // Counts BUSY cycles without m_ready; value k means k such cycles already elapsed.
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] wait_cnt;

  assign tmo = m_req_q && !bus.m_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || complete) begin
      wait_cnt <= '0;
    end else if (!bus.m_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT;
  assign tmo = 1'b0;
`endif

  // m_ready wins over a same-cycle timeout.
  assign complete = m_req_q && (bus.m_ready || tmo);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= SEL_R0;
      last     <= SEL_R1;
      m_req_q  <= 1'b0;
      r0_gnt_q <= 1'b0;
      r1_gnt_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.r0_req || bus.r1_req) begin
            state    <= BUSY;
            sel      <= winner;
            last     <= winner;
            m_req_q  <= 1'b1;
            r0_gnt_q <= (winner == SEL_R0);
            r1_gnt_q <= (winner == SEL_R1);
          end
        end
        BUSY: begin
          // A requester dropping req mid-access is ignored; only completion ends BUSY.
          if (complete) begin
            state    <= IDLE;
            m_req_q  <= 1'b0;
            r0_gnt_q <= 1'b0;
            r1_gnt_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel     = sel;
  assign bus.m_req   = m_req_q;
  assign bus.r0_gnt  = r0_gnt_q;
  assign bus.r1_gnt  = r1_gnt_q;
  assign bus.r0_done = complete && (sel == SEL_R0);
  assign bus.r1_done = complete && (sel == SEL_R1);
  assign bus.err     = tmo;
  assign bus.rdata   = tmo ? '0 : bus.m_rdata;

  // Write enable is gated by m_req so the port never sees a write while IDLE.
  assign bus.m_we = m_req_q && ((sel == SEL_R1) ? bus.r1_we : bus.r0_we);

  Mux u_addr_mux (
    .a (bus.r0_addr),
    .b (bus.r1_addr),
    .s (sel),
    .y (bus.m_addr)
  );

  Mux u_wdata_mux (
    .a (bus.r0_wdata),
    .b (bus.r1_wdata),
    .s (sel),
    .y (bus.m_wdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter (directed cases, then random traffic).
// Latency: checks every cycle against a transaction-level reference model.
// Backpressure: requesters hold their request until the model predicts their done.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: is an access open, who owns it, who won last, cycles waited.
  bit   mdl_busy = 1'b0;
  logic mdl_sel  = 1'b0;
  logic mdl_last = 1'b1;
  int   mdl_wait = 0;
  bit   fin0, fin1;
  int   n_done0 = 0;
  int   n_done1 = 0;
  logic grant_log[$];

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model, then
  // return 1 time unit after the rising edge so the caller can drive new inputs.
  task automatic step(input bit en);
    logic        exp_tmo, exp_done, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    @(negedge clk);
    exp_tmo = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    exp_tmo = mdl_busy && !bus.m_ready && (mdl_wait == TMO - 1);
`endif
    exp_done  = mdl_busy && (bus.m_ready || exp_tmo);
    exp_addr  = mdl_sel ? bus.r1_addr  : bus.r0_addr;
    exp_wdata = mdl_sel ? bus.r1_wdata : bus.r0_wdata;
    exp_we    = mdl_busy && (mdl_sel ? bus.r1_we : bus.r0_we);
    if (en) begin
      chk("m_req",   bus.m_req,   mdl_busy);
      chk("r0_gnt",  bus.r0_gnt,  mdl_busy && !mdl_sel);
      chk("r1_gnt",  bus.r1_gnt,  mdl_busy && mdl_sel);
      chk("sel",     bus.sel,     mdl_sel);
      chk("m_addr",  bus.m_addr,  exp_addr);
      chk("m_wdata", bus.m_wdata, exp_wdata);
      chk("m_we",    bus.m_we,    exp_we);
      chk("r0_done", bus.r0_done, exp_done && !mdl_sel);
      chk("r1_done", bus.r1_done, exp_done && mdl_sel);
      chk("err",     bus.err,     exp_tmo);
      if (exp_done) chk("rdata", bus.rdata, exp_tmo ? 32'h0 : bus.m_rdata);
    end
    if (bus.r0_done === 1'b1) n_done0++;
    if (bus.r1_done === 1'b1) n_done1++;
    if (mdl_busy && mdl_wait == 0) grant_log.push_back(bus.sel);
    fin0 = exp_done && !mdl_sel && !rst;
    fin1 = exp_done && mdl_sel && !rst;
    if (rst) begin
      mdl_busy = 1'b0; mdl_sel = 1'b0; mdl_last = 1'b1; mdl_wait = 0;
    end else if (!mdl_busy) begin
      if (bus.r0_req || bus.r1_req) begin
        if (bus.r0_req && bus.r1_req) mdl_sel = ~mdl_last;
        else                          mdl_sel = bus.r1_req;
        mdl_last = mdl_sel;
        mdl_busy = 1'b1;
        mdl_wait = 0;
      end
    end else if (exp_done) begin
      mdl_busy = 1'b0;
      mdl_wait = 0;
    end else begin
      mdl_wait++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    bus.r0_addr = '0;  bus.r1_addr = '0;
    bus.r0_wdata = '0; bus.r1_wdata = '0;
    bus.r0_we = 1'b0;  bus.r1_we = 1'b0;
    bus.m_ready = 1'b0; bus.m_rdata = '0;

    // Reset: first cycle precedes any clock edge, so only later cycles are checked.
    step(0);
    step(1);
    rst = 1'b0;
    step(1);

    // Single r0 read with m_ready in the 4th BUSY cycle.
    bus.r0_addr = 32'h0000_0040; bus.r0_we = 1'b0; bus.r0_wdata = 32'h1111_1111;
    bus.r0_req = 1'b1; bus.m_rdata = 32'hDEAD_BEEF; n_done0 = 0;
    step(1);
    repeat (3) step(1);
    bus.m_ready = 1'b1;
    step(1);
    bus.r0_req = 1'b0; bus.m_ready = 1'b0;
    chk("t1_done_count", n_done0, 1);
    chk("t1_sel", bus.sel, SEL_R0);
    step(1);

    // r1 write.
    bus.r1_addr = 32'h1234_5678; bus.r1_wdata = 32'hCAFE_F00D; bus.r1_we = 1'b1;
    bus.r1_req = 1'b1; n_done1 = 0;
    step(1);
    step(1);
    chk("t3_m_we", bus.m_we, 1'b1);
    chk("t3_m_wdata", bus.m_wdata, 32'hCAFE_F00D);
    chk("t3_r0_gnt", bus.r0_gnt, 1'b0);
    bus.m_ready = 1'b1;
    step(1);
    bus.r1_req = 1'b0; bus.m_ready = 1'b0; bus.r1_we = 1'b0;
    chk("t3_done_count", n_done1, 1);
    step(1);

    // Both saturated, memory always ready: strict alternation starting with r0.
    bus.r0_addr = 32'hAAAA_AAAA; bus.r1_addr = 32'hBBBB_BBBB;
    bus.r0_req = 1'b1; bus.r1_req = 1'b1; bus.m_ready = 1'b1;
    grant_log.delete(); n_done0 = 0; n_done1 = 0;
    repeat (8) step(1);
    bus.r0_req = 1'b0; bus.r1_req = 1'b0; bus.m_ready = 1'b0;
    chk("t2_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("t2_grant_order", grant_log[i], i % 2);
    chk("t2_done_count", n_done0 + n_done1, 4);
    step(1);

    // Reset two cycles into BUSY, then a fresh tie.
    bus.r1_req = 1'b1; n_done1 = 0;
    step(1);
    step(1);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0; bus.r0_req = 1'b1;
    chk("t4_m_req_after_rst", bus.m_req, 1'b0);
    chk("t4_sel_after_rst", bus.sel, SEL_R0);
    chk("t4_no_done", n_done1, 0);
    step(1);
    chk("t4_tie_sel", bus.sel, SEL_R0);
    chk("t4_tie_gnt", bus.r0_gnt, 1'b1);
    bus.m_ready = 1'b1;
    step(1);
    bus.r0_req = 1'b0;
    step(1);
    step(1);
    bus.r1_req = 1'b0; bus.m_ready = 1'b0;
    step(1);

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout abort, then m_ready arriving in the timeout cycle.
    bus.r0_req = 1'b1; n_done0 = 0;
    step(1);
    repeat (3) step(1);
    chk("t5_err", bus.err, 1'b1);
    chk("t5_done", bus.r0_done, 1'b1);
    step(1);
    bus.r0_req = 1'b0;
    chk("t5_idle", bus.m_req, 1'b0);
    chk("t5_done_count", n_done0, 1);
    step(1);
    bus.r0_req = 1'b1;
    step(1);
    repeat (3) step(1);
    bus.m_ready = 1'b1;
    chk("t5_ready_err", bus.err, 1'b0);
    chk("t5_ready_done", bus.r0_done, 1'b1);
    step(1);
    bus.r0_req = 1'b0; bus.m_ready = 1'b0;
    step(1);
`endif

    // Random traffic with occasional resets.
    repeat (1500) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.m_ready = ($urandom_range(0, 9) < 3);
      bus.m_rdata = $urandom;
      step(1);
      if (bus.r0_req) begin
        if (fin0) begin
          if ($urandom_range(0, 1) == 1) begin
            bus.r0_addr = $urandom; bus.r0_wdata = $urandom; bus.r0_we = $urandom_range(0, 1) == 1;
          end else bus.r0_req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.r0_req = 1'b1;
        bus.r0_addr = $urandom; bus.r0_wdata = $urandom; bus.r0_we = $urandom_range(0, 1) == 1;
      end
      if (bus.r1_req) begin
        if (fin1) begin
          if ($urandom_range(0, 1) == 1) begin
            bus.r1_addr = $urandom; bus.r1_wdata = $urandom; bus.r1_we = $urandom_range(0, 1) == 1;
          end else bus.r1_req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.r1_req = 1'b1;
        bus.r1_addr = $urandom; bus.r1_wdata = $urandom; bus.r1_we = $urandom_range(0, 1) == 1;
      end
    end

    rst = 1'b0; bus.r0_req = 1'b0; bus.r1_req = 1'b0; bus.m_ready = 1'b0;
    step(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
